pipeline_stage_regs: RTL and testbench

Bundles the three forward pipeline registers of the 5-stage RV32I core: IF/ID, ID/EX and EX/MEM. Each bank captures its upstream stage outputs on the rising clock edge and presents them to the next stage for one full cycle. It sits between fetch, decode, execute and memory logic in the core datapath. It has no hazard, stall or flush logic. MEM/WB is a separate block.

---
 rtl/core_pkg.sv | 58 +++++
 rtl/pipeline_stage_regs_pipe_reg.sv | 26 ++
 rtl/pipeline_stage_regs.sv | 150 +++++++++++++++
 tb/tb_pipeline_stage_regs.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg
//   Shared definitions for the RV32I core datapath.
//   - XLEN / REGW : datapath and register-address widths
//   - ALU_*       : 4-bit ALU operation codes carried on ALUControl
//   - *_t         : packed bundles held by the forward pipeline registers
package core_pkg;

   localparam int XLEN = 32;
   localparam int REGW = 5;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;

   // Control produced by decode and consumed in execute.
   typedef struct packed {
      logic       ALUSrc;
      logic       MemtoReg;
      logic       RegWrite;
      logic       MemRead;
      logic       MemWrite;
      logic [3:0] ALUControl;
   } id_ex_ctrl_t;

   // Control that survives into the memory stage; ALUSrc and ALUControl
   // have been consumed by execute and are dropped here.
   typedef struct packed {
      logic MemtoReg;
      logic RegWrite;
      logic MemRead;
      logic MemWrite;
   } ex_mem_ctrl_t;

   typedef struct packed {
      logic [XLEN-1:0] pc_plus_4;
      logic [XLEN-1:0] instruction;
   } if_id_t;

   typedef struct packed {
      id_ex_ctrl_t     ctrl;
      logic [XLEN-1:0] pc_plus_4;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm_ext;
      logic [REGW-1:0] rd_addr;
   } id_ex_t;

   typedef struct packed {
      ex_mem_ctrl_t    ctrl;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] rd2;
      logic [REGW-1:0] rd_addr;
   } ex_mem_t;

endpackage

// File: rtl/pipeline_stage_regs_pipe_reg.sv
// pipe_reg
//   Generic WIDTH-bit flop bank, rising-edge capture, asynchronous
//   active-low clear to all zeros. No enable: it loads on every edge.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-low clear
//   d     : value captured on each rising edge
//   q     : registered value
module pipe_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipeline_stage_regs.sv
// pipeline_stage_regs
//   The IF/ID, ID/EX and EX/MEM forward pipeline registers of the 5-stage
//   RV32I core. Each bank is a single pipe_reg over a packed bundle, so every
//   output is a flop output with exactly one cycle of latency per bank and
//   no input-to-output combinational path. No stall or flush handling.
//   An all-zero bank is a bubble: no register write, no memory access.
// Ports
//   clk, reset          : rising-edge clock; async active-low clear of all banks
//   if_*                : fetch outputs       -> id_* (IF/ID)
//   id_* (inputs)       : decode outputs      -> ex_* (ID/EX)
//   ex_alu_result       : execute result      -> mem_alu_result (EX/MEM)
//   ex_* (outputs)      : ID/EX contents; ex_rd2, ex_rd_addr and the memory
//                         controls also feed EX/MEM
//   mem_*               : EX/MEM contents
module pipeline_stage_regs
   import core_pkg::*;
(
   input  logic            clk,
   input  logic            reset,

   // IF/ID
   input  logic [XLEN-1:0] if_pc_plus_4,
   input  logic [XLEN-1:0] if_instruction,
   output logic [XLEN-1:0] id_pc_plus_4,
   output logic [XLEN-1:0] id_instruction,

   // ID/EX
   input  logic            id_ALUSrc,
   input  logic            id_MemtoReg,
   input  logic            id_RegWrite,
   input  logic            id_MemRead,
   input  logic            id_MemWrite,
   input  logic [3:0]      id_ALUControl,
   input  logic [XLEN-1:0] id_rd1,
   input  logic [XLEN-1:0] id_rd2,
   input  logic [XLEN-1:0] id_imm_ext,
   input  logic [REGW-1:0] id_rd_addr,
   output logic            ex_ALUSrc,
   output logic            ex_MemtoReg,
   output logic            ex_RegWrite,
   output logic            ex_MemRead,
   output logic            ex_MemWrite,
   output logic [3:0]      ex_ALUControl,
   output logic [XLEN-1:0] ex_pc_plus_4,
   output logic [XLEN-1:0] ex_rd1,
   output logic [XLEN-1:0] ex_rd2,
   output logic [XLEN-1:0] ex_imm_ext,
   output logic [REGW-1:0] ex_rd_addr,

   // EX/MEM
   input  logic [XLEN-1:0] ex_alu_result,
   output logic [XLEN-1:0] mem_alu_result,
   output logic [XLEN-1:0] mem_rd2,
   output logic [REGW-1:0] mem_rd_addr,
   output logic            mem_MemtoReg,
   output logic            mem_RegWrite,
   output logic            mem_MemRead,
   output logic            mem_MemWrite
);

   if_id_t  if_id_next,  if_id_reg;
   id_ex_t  id_ex_next,  id_ex_reg;
   ex_mem_t ex_mem_next, ex_mem_reg;

   // ---------------- IF/ID ----------------
   assign if_id_next = '{
      pc_plus_4:   if_pc_plus_4,
      instruction: if_instruction
   };

   pipe_reg #(.WIDTH($bits(if_id_t))) u_if_id (
      .clk   (clk),
      .reset (reset),
      .d     (if_id_next),
      .q     (if_id_reg)
   );

   assign id_pc_plus_4   = if_id_reg.pc_plus_4;
   assign id_instruction = if_id_reg.instruction;

   // ---------------- ID/EX ----------------
   // The PC+4 forwarded to execute is the IF/ID register output, not a
   // decode input, so it trails the fetch value by two edges.
   assign id_ex_next = '{
      ctrl: '{
         ALUSrc:     id_ALUSrc,
         MemtoReg:   id_MemtoReg,
         RegWrite:   id_RegWrite,
         MemRead:    id_MemRead,
         MemWrite:   id_MemWrite,
         ALUControl: id_ALUControl
      },
      pc_plus_4: if_id_reg.pc_plus_4,
      rd1:       id_rd1,
      rd2:       id_rd2,
      imm_ext:   id_imm_ext,
      rd_addr:   id_rd_addr
   };

   pipe_reg #(.WIDTH($bits(id_ex_t))) u_id_ex (
      .clk   (clk),
      .reset (reset),
      .d     (id_ex_next),
      .q     (id_ex_reg)
   );

   assign ex_ALUSrc     = id_ex_reg.ctrl.ALUSrc;
   assign ex_MemtoReg   = id_ex_reg.ctrl.MemtoReg;
   assign ex_RegWrite   = id_ex_reg.ctrl.RegWrite;
   assign ex_MemRead    = id_ex_reg.ctrl.MemRead;
   assign ex_MemWrite   = id_ex_reg.ctrl.MemWrite;
   assign ex_ALUControl = id_ex_reg.ctrl.ALUControl;
   assign ex_pc_plus_4  = id_ex_reg.pc_plus_4;
   assign ex_rd1        = id_ex_reg.rd1;
   assign ex_rd2        = id_ex_reg.rd2;
   assign ex_imm_ext    = id_ex_reg.imm_ext;
   assign ex_rd_addr    = id_ex_reg.rd_addr;

   // ---------------- EX/MEM ----------------
   // Store data, destination and memory-side controls are taken from the
   // ID/EX register outputs (pre-edge values), so they advance exactly one
   // stage per edge. ALUSrc/ALUControl are not carried further.
   assign ex_mem_next = '{
      ctrl: '{
         MemtoReg: id_ex_reg.ctrl.MemtoReg,
         RegWrite: id_ex_reg.ctrl.RegWrite,
         MemRead:  id_ex_reg.ctrl.MemRead,
         MemWrite: id_ex_reg.ctrl.MemWrite
      },
      alu_result: ex_alu_result,
      rd2:        id_ex_reg.rd2,
      rd_addr:    id_ex_reg.rd_addr
   };

   pipe_reg #(.WIDTH($bits(ex_mem_t))) u_ex_mem (
      .clk   (clk),
      .reset (reset),
      .d     (ex_mem_next),
      .q     (ex_mem_reg)
   );

   assign mem_alu_result = ex_mem_reg.alu_result;
   assign mem_rd2        = ex_mem_reg.rd2;
   assign mem_rd_addr    = ex_mem_reg.rd_addr;
   assign mem_MemtoReg   = ex_mem_reg.ctrl.MemtoReg;
   assign mem_RegWrite   = ex_mem_reg.ctrl.RegWrite;
   assign mem_MemRead    = ex_mem_reg.ctrl.MemRead;
   assign mem_MemWrite   = ex_mem_reg.ctrl.MemWrite;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// tb_pipeline_stage_regs
//   Directed, self-checking bench for pipeline_stage_regs. Inputs change on
//   the falling edge; outputs are sampled on the following falling edge,
//   i.e. half a cycle after the capturing rising edge.
module tb_pipeline_stage_regs;
   import core_pkg::*;

   logic            clk;
   logic            reset;
   logic [XLEN-1:0] if_pc_plus_4, if_instruction;
   logic [XLEN-1:0] id_pc_plus_4, id_instruction;
   logic            id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite;
   logic [3:0]      id_ALUControl;
   logic [XLEN-1:0] id_rd1, id_rd2, id_imm_ext;
   logic [REGW-1:0] id_rd_addr;
   logic            ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite;
   logic [3:0]      ex_ALUControl;
   logic [XLEN-1:0] ex_pc_plus_4, ex_rd1, ex_rd2, ex_imm_ext;
   logic [REGW-1:0] ex_rd_addr;
   logic [XLEN-1:0] ex_alu_result;
   logic [XLEN-1:0] mem_alu_result, mem_rd2;
   logic [REGW-1:0] mem_rd_addr;
   logic            mem_MemtoReg, mem_RegWrite, mem_MemRead, mem_MemWrite;

   int checks   = 0;
   int failures = 0;

   pipeline_stage_regs dut (
      .clk            (clk),
      .reset          (reset),
      .if_pc_plus_4   (if_pc_plus_4),
      .if_instruction (if_instruction),
      .id_pc_plus_4   (id_pc_plus_4),
      .id_instruction (id_instruction),
      .id_ALUSrc      (id_ALUSrc),
      .id_MemtoReg    (id_MemtoReg),
      .id_RegWrite    (id_RegWrite),
      .id_MemRead     (id_MemRead),
      .id_MemWrite    (id_MemWrite),
      .id_ALUControl  (id_ALUControl),
      .id_rd1         (id_rd1),
      .id_rd2         (id_rd2),
      .id_imm_ext     (id_imm_ext),
      .id_rd_addr     (id_rd_addr),
      .ex_ALUSrc      (ex_ALUSrc),
      .ex_MemtoReg    (ex_MemtoReg),
      .ex_RegWrite    (ex_RegWrite),
      .ex_MemRead     (ex_MemRead),
      .ex_MemWrite    (ex_MemWrite),
      .ex_ALUControl  (ex_ALUControl),
      .ex_pc_plus_4   (ex_pc_plus_4),
      .ex_rd1         (ex_rd1),
      .ex_rd2         (ex_rd2),
      .ex_imm_ext     (ex_imm_ext),
      .ex_rd_addr     (ex_rd_addr),
      .ex_alu_result  (ex_alu_result),
      .mem_alu_result (mem_alu_result),
      .mem_rd2        (mem_rd2),
      .mem_rd_addr    (mem_rd_addr),
      .mem_MemtoReg   (mem_MemtoReg),
      .mem_RegWrite   (mem_RegWrite),
      .mem_MemRead    (mem_MemRead),
      .mem_MemWrite   (mem_MemWrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // c = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite}
   task automatic drive_all(input logic [31:0] d, input logic [4:0] a,
                            input logic [4:0] c, input logic [3:0] alu);
      if_pc_plus_4   = d;
      if_instruction = d;
      id_rd1         = d;
      id_rd2         = d;
      id_imm_ext     = d;
      ex_alu_result  = d;
      id_rd_addr     = a;
      id_ALUSrc      = c[4];
      id_MemtoReg    = c[3];
      id_RegWrite    = c[2];
      id_MemRead     = c[1];
      id_MemWrite    = c[0];
      id_ALUControl  = alu;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".id_pc"},      id_pc_plus_4,   32'h0);
      check({tag, ".id_instr"},   id_instruction, 32'h0);
      check({tag, ".ex_ALUSrc"},  ex_ALUSrc,      32'h0);
      check({tag, ".ex_MtoR"},    ex_MemtoReg,    32'h0);
      check({tag, ".ex_RegW"},    ex_RegWrite,    32'h0);
      check({tag, ".ex_MemR"},    ex_MemRead,     32'h0);
      check({tag, ".ex_MemW"},    ex_MemWrite,    32'h0);
      check({tag, ".ex_ALUCtl"},  ex_ALUControl,  32'h0);
      check({tag, ".ex_pc"},      ex_pc_plus_4,   32'h0);
      check({tag, ".ex_rd1"},     ex_rd1,         32'h0);
      check({tag, ".ex_rd2"},     ex_rd2,         32'h0);
      check({tag, ".ex_imm"},     ex_imm_ext,     32'h0);
      check({tag, ".ex_rd_addr"}, ex_rd_addr,     32'h0);
      check({tag, ".mem_alu"},    mem_alu_result, 32'h0);
      check({tag, ".mem_rd2"},    mem_rd2,        32'h0);
      check({tag, ".mem_rd_addr"},mem_rd_addr,    32'h0);
      check({tag, ".mem_MtoR"},   mem_MemtoReg,   32'h0);
      check({tag, ".mem_RegW"},   mem_RegWrite,   32'h0);
      check({tag, ".mem_MemR"},   mem_MemRead,    32'h0);
      check({tag, ".mem_MemW"},   mem_MemWrite,   32'h0);
   endtask

   initial begin
      logic [31:0] d, prev_d;
      logic [4:0]  a, prev_a, c, prev_c;
      logic [3:0]  alu;

      // ---- reset held low with all inputs at ones ----
      reset = 1'b0;
      drive_all(32'hFFFF_FFFF, 5'h1F, 5'h1F, 4'hF);
      #1;
      check_all_zero("rst_pre_edge");
      repeat (2) @(negedge clk);
      check_all_zero("rst_after_edges");

      // ---- release: first edge loads, EX/MEM chained fields lag one edge ----
      reset = 1'b1;
      @(negedge clk);
      check("rel1.id_instr",    id_instruction, 32'hFFFF_FFFF);
      check("rel1.id_pc",       id_pc_plus_4,   32'hFFFF_FFFF);
      check("rel1.ex_rd1",      ex_rd1,         32'hFFFF_FFFF);
      check("rel1.ex_imm",      ex_imm_ext,     32'hFFFF_FFFF);
      check("rel1.ex_rd_addr",  ex_rd_addr,     32'h1F);
      check("rel1.ex_ALUCtl",   ex_ALUControl,  32'hF);
      check("rel1.ex_ALUSrc",   ex_ALUSrc,      32'h1);
      check("rel1.ex_pc",       ex_pc_plus_4,   32'h0);
      check("rel1.mem_alu",     mem_alu_result, 32'hFFFF_FFFF);
      check("rel1.mem_rd2",     mem_rd2,        32'h0);
      check("rel1.mem_rd_addr", mem_rd_addr,    32'h0);
      check("rel1.mem_MemW",    mem_MemWrite,   32'h0);
      @(negedge clk);
      check("rel2.ex_pc",       ex_pc_plus_4,   32'hFFFF_FFFF);
      check("rel2.mem_rd2",     mem_rd2,        32'hFFFF_FFFF);
      check("rel2.mem_rd_addr", mem_rd_addr,    32'h1F);
      check("rel2.mem_MemW",    mem_MemWrite,   32'h1);
      check("rel2.mem_MtoR",    mem_MemtoReg,   32'h1);

      // ---- instruction stream through IF/ID ----
      drive_all(32'h0, 5'h0, 5'h0, 4'h0);
      if_instruction = 32'h0010_0093;
      if_pc_plus_4   = 32'h4;
      @(negedge clk);
      check("strm1.id_instr",   id_instruction, 32'h0010_0093);
      check("strm1.id_pc",      id_pc_plus_4,   32'h4);
      check("strm1.ex_pc",      ex_pc_plus_4,   32'hFFFF_FFFF);
      check("strm1.ex_RegW",    ex_RegWrite,    32'h0);
      if_instruction = 32'h0020_0113;
      if_pc_plus_4   = 32'h8;
      @(negedge clk);
      check("strm2.id_instr",   id_instruction, 32'h0020_0113);
      check("strm2.id_pc",      id_pc_plus_4,   32'h8);
      check("strm2.ex_pc",      ex_pc_plus_4,   32'h4);

      // ---- ID/EX transfer ----
      if_instruction = 32'h0;
      if_pc_plus_4   = 32'hC;
      id_ALUSrc      = 1'b1;
      id_RegWrite    = 1'b1;
      id_ALUControl  = ALU_ADD;
      id_rd1         = 32'h0;
      id_imm_ext     = 32'h1;
      id_rd_addr     = 5'd1;
      id_rd2         = 32'hDEAD_BEEF;
      @(negedge clk);
      check("idex.ex_ALUSrc",   ex_ALUSrc,      32'h1);
      check("idex.ex_RegW",     ex_RegWrite,    32'h1);
      check("idex.ex_MtoR",     ex_MemtoReg,    32'h0);
      check("idex.ex_MemR",     ex_MemRead,     32'h0);
      check("idex.ex_MemW",     ex_MemWrite,    32'h0);
      check("idex.ex_ALUCtl",   ex_ALUControl,  32'h2);
      check("idex.ex_rd1",      ex_rd1,         32'h0);
      check("idex.ex_imm",      ex_imm_ext,     32'h1);
      check("idex.ex_rd_addr",  ex_rd_addr,     32'h1);
      check("idex.ex_rd2",      ex_rd2,         32'hDEAD_BEEF);
      check("idex.ex_pc",       ex_pc_plus_4,   32'h8);
      check("idex.id_pc",       id_pc_plus_4,   32'hC);

      // ---- EX/MEM chaining ----
      drive_all(32'h0, 5'h0, 5'h0, 4'h0);
      id_MemWrite = 1'b1;
      id_rd2      = 32'h1234_5678;
      id_rd_addr  = 5'd5;
      @(negedge clk);
      check("chn1.ex_MemW",     ex_MemWrite,    32'h1);
      check("chn1.ex_rd2",      ex_rd2,         32'h1234_5678);
      check("chn1.mem_rd2",     mem_rd2,        32'hDEAD_BEEF);
      check("chn1.mem_RegW",    mem_RegWrite,   32'h1);
      check("chn1.mem_rd_addr", mem_rd_addr,    32'h1);
      check("chn1.mem_MemW",    mem_MemWrite,   32'h0);
      drive_all(32'h0, 5'h0, 5'h0, 4'h0);
      ex_alu_result = 32'h40;
      @(negedge clk);
      check("chn2.mem_MemW",    mem_MemWrite,   32'h1);
      check("chn2.mem_rd2",     mem_rd2,        32'h1234_5678);
      check("chn2.mem_rd_addr", mem_rd_addr,    32'h5);
      check("chn2.mem_alu",     mem_alu_result, 32'h40);
      check("chn2.mem_RegW",    mem_RegWrite,   32'h0);
      check("chn2.ex_MemW",     ex_MemWrite,    32'h0);

      // ---- asynchronous reset mid-stream ----
      drive_all(32'hA5A5_5A5A, 5'h15, 5'h1F, 4'h7);
      repeat (2) @(negedge clk);
      check("pre_arst.mem_rd2", mem_rd2,        32'hA5A5_5A5A);
      check("pre_arst.id_instr",id_instruction, 32'hA5A5_5A5A);
      #1 reset = 1'b0;
      #1;
      check_all_zero("arst");
      #1 reset = 1'b1;
      drive_all(32'h3C3C_C3C3, 5'h0A, 5'h0A, 4'h6);
      @(negedge clk);
      check("reload.id_instr",   id_instruction, 32'h3C3C_C3C3);
      check("reload.ex_rd1",     ex_rd1,         32'h3C3C_C3C3);
      check("reload.ex_rd_addr", ex_rd_addr,     32'h0A);
      check("reload.ex_MtoR",    ex_MemtoReg,    32'h1);
      check("reload.ex_RegW",    ex_RegWrite,    32'h0);
      check("reload.ex_MemR",    ex_MemRead,     32'h1);
      check("reload.ex_ALUCtl",  ex_ALUControl,  32'h6);
      check("reload.ex_pc",      ex_pc_plus_4,   32'h0);
      check("reload.mem_alu",    mem_alu_result, 32'h3C3C_C3C3);
      check("reload.mem_rd2",    mem_rd2,        32'h0);
      check("reload.mem_rd_addr",mem_rd_addr,    32'h0);
      check("reload.mem_MemR",   mem_MemRead,    32'h0);

      // ---- walking ones on every field ----
      drive_all(32'h0, 5'h0, 5'h0, 4'h0);
      @(negedge clk);
      prev_d = 32'h0;
      prev_a = 5'h0;
      prev_c = 5'h0;
      for (int i = 0; i < 32; i++) begin
         d   = 32'h1 << i;
         a   = 5'h1 << (i % 5);
         c   = 5'h1 << ((i + 2) % 5);
         alu = 4'h1 << (i % 4);
         drive_all(d, a, c, alu);
         @(negedge clk);
         check($sformatf("walk%0d.id_instr", i),   id_instruction, d);
         check($sformatf("walk%0d.id_pc", i),      id_pc_plus_4,   d);
         check($sformatf("walk%0d.ex_pc", i),      ex_pc_plus_4,   prev_d);
         check($sformatf("walk%0d.ex_rd1", i),     ex_rd1,         d);
         check($sformatf("walk%0d.ex_rd2", i),     ex_rd2,         d);
         check($sformatf("walk%0d.ex_imm", i),     ex_imm_ext,     d);
         check($sformatf("walk%0d.ex_rd_addr", i), ex_rd_addr,     {27'h0, a});
         check($sformatf("walk%0d.ex_ctrl", i),
               {27'h0, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite},
               {27'h0, c});
         check($sformatf("walk%0d.ex_ALUCtl", i),  ex_ALUControl,  {28'h0, alu});
         check($sformatf("walk%0d.mem_alu", i),    mem_alu_result, d);
         check($sformatf("walk%0d.mem_rd2", i),    mem_rd2,        prev_d);
         check($sformatf("walk%0d.mem_rd_addr", i),mem_rd_addr,    {27'h0, prev_a});
         check($sformatf("walk%0d.mem_ctrl", i),
               {28'h0, mem_MemtoReg, mem_RegWrite, mem_MemRead, mem_MemWrite},
               {28'h0, prev_c[3:0]});
         prev_d = d;
         prev_a = a;
         prev_c = c;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
